dtfag_agu_seq: RTL
==================

// Module: dtfag_agu_seq
// PURPOSE
//  Sequencer for the DTFAG twiddle-factor address generator (DTFAG_AGU).
//  - On a start pulse, sweeps the index triple (i, t, j) through a programmable nested range.
//  - Drives DTFAG_i/DTFAG_t/DTFAG_j and the active-low ROM chip enable into the AGU, one triple per cycle.
//  - Reports busy/done to the FFT stage controller.
//  - Sits between the FFT stage controller and DTFAG_AGU; the three twiddle ROMs follow the AGU.
// PARAMETERS
//  RADIX_W   `radix_width (4)  width of i, t, j indices and their limits
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        1-cycle pulse: latch cfg_*, begin sweep (ignored unless IDLE)
//  abort        in   1        synchronous abort: return to IDLE next cycle, no done pulse
//  stall        in   1        hold current triple, do not advance (DTFAG_SEQ_STALL_EN only)
//  cfg_i_max    in   RADIX_W  last value of i (outer loop), inclusive
//  cfg_t_max    in   RADIX_W  last value of t (middle loop), inclusive
//  cfg_j_max    in   RADIX_W  last value of j (inner loop), inclusive
//  DTFAG_i      out  RADIX_W  index i to AGU
//  DTFAG_t      out  RADIX_W  index t to AGU
//  DTFAG_j      out  RADIX_W  index j to AGU
//  ROM_CEN      out  1        ROM chip enable to AGU ROM_CEN_in, active low
//  busy         out  1        high in RUN
//  done         out  1        1-cycle pulse after the last triple is issued
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: DTFAG_i/t/j = 0, ROM_CEN = 1, busy = 0, done = 0, state = IDLE.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: ROM_CEN = 1 and the indices hold their last value.
//      - start = 1: latch cfg_i_max/cfg_t_max/cfg_j_max into shadow registers; load i = t = j = 0; go to RUN.
//      - The first triple (0,0,0) with ROM_CEN = 0 appears on the cycle after start.
//    - RUN: ROM_CEN = 0 and busy = 1. Each non-stalled cycle advances the counters:
//      - j++;
//      - if j == j_max: j = 0 and t++;
//      - if also t == t_max: t = 0 and i++.
//      - The triple (i_max, t_max, j_max) is the last one. The cycle after it is issued: go to DONE, ROM_CEN = 1.
//    - DONE: done = 1 for exactly one cycle, busy = 0, indices hold; then go to IDLE.
//  - Triple count = (i_max+1)*(t_max+1)*(j_max+1). All limits 0 gives exactly one triple, then DONE.
//  - Counters never exceed the latched max. All-ones limits sweep the full 2^RADIX_W range with no overflow.
//  - cfg_* changes during RUN have no effect; only the shadow copies are used.
//  - start during RUN or DONE is ignored.
//  - abort has priority over start, stall and advance:
//    - from RUN or DONE: go to IDLE next cycle, ROM_CEN = 1, no done pulse;
//    - in IDLE: no effect.
//  - abort and start in the same IDLE cycle: stay IDLE.
//  - Stalled cycle in RUN: indices hold and ROM_CEN stays 0 (the ROM re-reads the same address).
//  - Stall on the last triple: hold; DONE is entered only after an unstalled cycle.
//  - Stall is ignored outside RUN.
//  - rst_n asserted mid-sweep: immediate return to reset values; no done pulse.
//  - ROM data is valid one cycle after the corresponding ROM_CEN = 0 cycle (synchronous ROM). The sequencer adds no extra latency.
// CONFIGURATION
//  DTFAG_SEQ_STALL_EN defined:
//   - the stall port exists and behaves as described in BEHAVIOUR.
//  DTFAG_SEQ_STALL_EN undefined:
//   - the stall port is absent and the internal stall is tied to 0;
//   - the sweep always advances one triple per RUN cycle;
//   - RUN lasts exactly the triple count in cycles.
// TESTING
//  1. Reset: rst_n=0 -> DTFAG_i/t/j=0, ROM_CEN=1, busy=0, done=0. Release, no start -> outputs unchanged.
//  2. Small sweep: cfg i/t/j max = 1/1/1, start.
//     -> 8 triples in order 000,001,010,011,100,101,110,111 (i,t,j);
//     -> ROM_CEN=0 for 8 cycles; done pulses 1 cycle later; busy low.
//  3. Full range: all max = 15 -> 4096 consecutive triples ending at (15,15,15); no wrap past max; one done.
//  4. Degenerate case and config latch:
//     - all max = 0 -> one triple (0,0,0), then done;
//     - cfg changed to 3 during RUN -> no extra triples.
//  5. Stall (DTFAG_SEQ_STALL_EN): max 0/0/3, stall high 2 cycles at j=2
//     -> j=2 held 3 cycles with ROM_CEN=0; then j=3; done; RUN lasts 6 cycles.
//  6. Abort and reset mid-sweep:
//     - abort at triple (0,1,0) -> IDLE next cycle, ROM_CEN=1, no done;
//     - later start -> restarts at (0,0,0);
//     - repeat with rst_n pulse -> reset values.

Source files
------------

// File: rtl/dtfag_agu_seq_if.sv
// dtfag_agu_seq_if: bus between the FFT stage controller (master) and the
// DTFAG twiddle-address sequencer (slave).
//   start, abort        controller commands (start is a 1-cycle pulse)
//   stall               hold current triple (only when DTFAG_SEQ_STALL_EN)
//   cfg_i/t/j_max       inclusive loop limits, latched on start
//   DTFAG_i/t/j         index triple to DTFAG_AGU
//   ROM_CEN             active-low ROM chip enable to the AGU
//   busy, done          sweep status back to the controller
// Optional feature macro: DTFAG_SEQ_STALL_EN.
`ifndef RADIX_WIDTH
`define RADIX_WIDTH 4
`endif

interface dtfag_agu_seq_if #(
  parameter int unsigned RADIX_W = `RADIX_WIDTH
);
  logic               start;
  logic               abort;
`ifdef DTFAG_SEQ_STALL_EN
  logic               stall;
`endif
  logic [RADIX_W-1:0] cfg_i_max;
  logic [RADIX_W-1:0] cfg_t_max;
  logic [RADIX_W-1:0] cfg_j_max;
  logic [RADIX_W-1:0] DTFAG_i;
  logic [RADIX_W-1:0] DTFAG_t;
  logic [RADIX_W-1:0] DTFAG_j;
  logic               ROM_CEN;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, cfg_i_max, cfg_t_max, cfg_j_max,
`ifdef DTFAG_SEQ_STALL_EN
    output stall,
`endif
    input  DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN, busy, done
  );

  modport slave (
    input  start, abort, cfg_i_max, cfg_t_max, cfg_j_max,
`ifdef DTFAG_SEQ_STALL_EN
    input  stall,
`endif
    output DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN, busy, done
  );
endinterface

// File: rtl/dtfag_agu_seq.sv
// dtfag_agu_seq: sequencer for the DTFAG twiddle-factor address generator.
// On start it latches the loop limits and sweeps (i, t, j) as a nested
// counter (j innermost), issuing one triple per cycle with ROM_CEN low,
// then pulses done for one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dtfag_agu_seq_if.slave (commands, limits, triple, ROM_CEN, status)
// Optional feature macro: DTFAG_SEQ_STALL_EN (adds the stall input; when
// undefined the sweep advances every RUN cycle).
`ifndef RADIX_WIDTH
`define RADIX_WIDTH 4
`endif

module dtfag_agu_seq #(
  parameter int unsigned RADIX_W = `RADIX_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  dtfag_agu_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [RADIX_W-1:0] i_q, i_d, t_q, t_d, j_q, j_d;
  logic [RADIX_W-1:0] i_max_q, i_max_d, t_max_q, t_max_d, j_max_q, j_max_d;
  logic               rom_cen_q, rom_cen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stall_w;
  logic               last_w;

`ifdef DTFAG_SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  // Final triple is detected before advancing, so counters never pass max.
  assign last_w = (i_q == i_max_q) && (t_q == t_max_q) && (j_q == j_max_q);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    t_d       = t_q;
    j_d       = j_q;
    i_max_d   = i_max_q;
    t_max_d   = t_max_q;
    j_max_d   = j_max_q;
    rom_cen_d = rom_cen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        rom_cen_d = 1'b1;
        busy_d    = 1'b0;
        if (bus.start && !bus.abort) begin
          i_max_d   = bus.cfg_i_max;
          t_max_d   = bus.cfg_t_max;
          j_max_d   = bus.cfg_j_max;
          i_d       = '0;
          t_d       = '0;
          j_d       = '0;
          rom_cen_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          rom_cen_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (stall_w) begin
          // hold triple, ROM_CEN stays low so the ROM re-reads the address
        end else if (last_w) begin
          rom_cen_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (j_q == j_max_q) begin
          j_d = '0;
          if (t_q == t_max_q) begin
            t_d = '0;
            i_d = i_q + RADIX_W'(1);
          end else begin
            t_d = t_q + RADIX_W'(1);
          end
        end else begin
          j_d = j_q + RADIX_W'(1);
        end
      end

      DONE: begin
        rom_cen_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        rom_cen_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      t_q       <= '0;
      j_q       <= '0;
      i_max_q   <= '0;
      t_max_q   <= '0;
      j_max_q   <= '0;
      rom_cen_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      t_q       <= t_d;
      j_q       <= j_d;
      i_max_q   <= i_max_d;
      t_max_q   <= t_max_d;
      j_max_q   <= j_max_d;
      rom_cen_q <= rom_cen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.DTFAG_i = i_q;
  assign bus.DTFAG_t = t_q;
  assign bus.DTFAG_j = j_q;
  assign bus.ROM_CEN = rom_cen_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
